// File: rtl/regfile_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : regfile_arbiter                                            |
// | Description : Round-robin arbiter sharing one register-file port among   |
// |               NREQ requesters. Define REGFILE_ARB_FIXED_PRIO_EN for      |
// |               fixed lowest-index priority.                               |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module regfile_arbiter #(
  parameter int NREQ   = 2,
  parameter int AW     = 12,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic               axi_aclk,
  input  logic               axi_aresetn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ack,
  output logic [DW-1:0]      req_rdata,
  output logic               regfile_en,
  output logic               regfile_we,
  output logic [AW-1:0]      regfile_addr,
  output logic [DW-1:0]      regfile_din,
  input  logic [DW-1:0]      regfile_dout,
  output logic               busy
);

  localparam int c_idx_w = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_cnt_w = $clog2(RD_LAT + 1);

  localparam logic [1:0] c_s_idle  = 2'd0;
  localparam logic [1:0] c_s_issue = 2'd1;
  localparam logic [1:0] c_s_wait  = 2'd2;
  localparam logic [1:0] c_s_ack   = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [c_idx_w-1:0] r_winner;
  logic               r_we;
  logic [AW-1:0]      r_addr;
  logic [DW-1:0]      r_wdata;
  logic [DW-1:0]      r_rdata;
  logic [c_cnt_w-1:0] r_wait_cnt;
  logic               w_last_wait;
  logic               w_found;
  logic [c_idx_w-1:0] w_grant;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_found = 1'b1;
        w_grant = c_idx_w'(i);
      end
    end
  end
`else
  logic [c_idx_w-1:0] r_last_grant;
  logic               w_hi_found;
  logic [c_idx_w-1:0] w_hi_grant;

  // Lowest requester above last_grant wins; otherwise wrap to the lowest overall.
  always_comb begin
    w_found    = 1'b0;
    w_grant    = '0;
    w_hi_found = 1'b0;
    w_hi_grant = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_found = 1'b1;
        w_grant = c_idx_w'(i);
        if (c_idx_w'(i) > r_last_grant) begin
          w_hi_found = 1'b1;
          w_hi_grant = c_idx_w'(i);
        end
      end
    end
    if (w_hi_found) begin
      w_grant = w_hi_grant;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_last_grant <= c_idx_w'(NREQ - 1);
    end else if (r_state == c_s_idle && w_found) begin
      r_last_grant <= w_grant;
    end
  end
`endif

  assign w_last_wait = (r_wait_cnt == c_cnt_w'(RD_LAT - 1));

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state <= c_s_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_s_idle:  if (w_found) w_state_next = c_s_issue;
      c_s_issue: w_state_next = r_we ? c_s_ack : c_s_wait;
      c_s_wait:  if (w_last_wait) w_state_next = c_s_ack;
      default:   w_state_next = c_s_idle;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_winner   <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_wait_cnt <= '0;
    end else begin
      if (r_state == c_s_idle && w_found) begin
        r_winner <= w_grant;
        r_we     <= req_we[w_grant];
        r_addr   <= req_addr[w_grant*AW +: AW];
        r_wdata  <= req_wdata[w_grant*DW +: DW];
      end
      if (r_state == c_s_issue) begin
        r_wait_cnt <= '0;
      end else if (r_state == c_s_wait) begin
        r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
        if (w_last_wait) begin
          r_rdata <= regfile_dout;
        end
      end
    end
  end

  // Outputs decode registered state only, so inputs never reach them combinationally.
  always_comb begin
    regfile_en   = (r_state == c_s_issue);
    regfile_we   = regfile_en & r_we;
    regfile_addr = regfile_en ? r_addr : '0;
    regfile_din  = regfile_en ? r_wdata : '0;
    busy         = (r_state != c_s_idle);
    req_rdata    = r_rdata;
    req_ack      = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ack[i] = (r_state == c_s_ack) && (r_winner == c_idx_w'(i));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_arbiter.sv
`default_nettype none
// Directed testbench for regfile_arbiter: one RD_LAT=1 instance with a
// register-file model and one RD_LAT=3 instance fed a per-cycle data pattern.
module tb_regfile_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic axi_aclk = 1'b0;
  logic axi_aresetn = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  int cyc = 0;
  always @(posedge axi_aclk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [1:0]      req_valid, req_we, req_ack;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   req_rdata, rf_din, rf_dout;
  logic            rf_en, rf_we, busy;
  logic [AW-1:0]   rf_addr;

  logic [1:0]      req_valid3, req_we3, req_ack3;
  logic [2*AW-1:0] req_addr3;
  logic [2*DW-1:0] req_wdata3;
  logic [DW-1:0]   req_rdata3, rf_din3, rf_dout3;
  logic            rf_en3, rf_we3, busy3;
  logic [AW-1:0]   rf_addr3;

  regfile_arbiter #(.NREQ(2), .AW(AW), .DW(DW), .RD_LAT(1)) u_dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_rdata(req_rdata),
    .regfile_en(rf_en), .regfile_we(rf_we), .regfile_addr(rf_addr),
    .regfile_din(rf_din), .regfile_dout(rf_dout), .busy(busy)
  );

  regfile_arbiter #(.NREQ(2), .AW(AW), .DW(DW), .RD_LAT(3)) u_dut3 (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .req_valid(req_valid3), .req_we(req_we3), .req_addr(req_addr3), .req_wdata(req_wdata3),
    .req_ack(req_ack3), .req_rdata(req_rdata3),
    .regfile_en(rf_en3), .regfile_we(rf_we3), .regfile_addr(rf_addr3),
    .regfile_din(rf_din3), .regfile_dout(rf_dout3), .busy(busy3)
  );

  // Register-file model: data is valid for exactly one cycle after a read strobe.
  logic [DW-1:0] mem [0:15];
  always @(posedge axi_aclk) begin
    if (rf_en && rf_we) mem[rf_addr[5:2]] <= rf_din;
    rf_dout <= (rf_en && !rf_we) ? mem[rf_addr[5:2]] : 32'hDEAD_BEEF;
  end

  assign rf_dout3 = {16'h3000, cyc[15:0]};

  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic test_reset();
    axi_aresetn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 2'($urandom); req_we = 2'($urandom);
      req_addr = 24'($urandom); req_wdata = {$urandom, $urandom};
      req_valid3 = 2'($urandom); req_we3 = 2'($urandom);
      req_addr3 = 24'($urandom); req_wdata3 = {$urandom, $urandom};
      step();
      checks++;
      if ({req_ack, req_rdata, rf_en, rf_we, rf_addr, rf_din, busy} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got ack=%b rdata=%h en=%b we=%b addr=%h din=%h busy=%b, required all 0",
                 req_ack, req_rdata, rf_en, rf_we, rf_addr, rf_din, busy);
      end
      checks++;
      if ({req_ack3, req_rdata3, rf_en3, rf_we3, rf_addr3, rf_din3, busy3} !== '0) begin
        errors++;
        $display("FAIL reset_outputs_lat3: got ack=%b rdata=%h en=%b busy=%b, required all 0",
                 req_ack3, req_rdata3, rf_en3, busy3);
      end
    end
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    req_valid3 = '0; req_we3 = '0; req_addr3 = '0; req_wdata3 = '0;
    step();
    axi_aresetn = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || rf_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b en=%b, required 0 0", busy, rf_en);
    end
  endtask

  task automatic test_write();
    req_valid = 2'b01; req_we = 2'b01;
    req_addr[0 +: AW] = 12'h008; req_wdata[0 +: DW] = 32'hA5A5_A5A5;
    checks++;
    if (rf_en !== 1'b0) begin
      errors++; $display("FAIL write_c_no_en: got en=%b, required 0", rf_en);
    end
    step();
    checks++;
    if ({rf_en, rf_we, rf_addr, rf_din} !== {1'b1, 1'b1, 12'h008, 32'hA5A5_A5A5}) begin
      errors++;
      $display("FAIL write_issue: got en=%b we=%b addr=%h din=%h, required 1 1 008 a5a5a5a5",
               rf_en, rf_we, rf_addr, rf_din);
    end
    step();
    checks++;
    if (req_ack !== 2'b01 || rf_en !== 1'b0 || rf_addr !== '0 || rf_din !== '0) begin
      errors++;
      $display("FAIL write_ack: got ack=%b en=%b addr=%h din=%h, required 01 0 000 0",
               req_ack, rf_en, rf_addr, rf_din);
    end
    req_valid = 2'b00;
    step();
    checks++;
    if (req_ack !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL write_done: got ack=%b busy=%b, required 00 0", req_ack, busy);
    end
  endtask

  task automatic test_read();
    req_valid = 2'b10; req_we = 2'b00;
    req_addr[AW +: AW] = 12'h004; req_wdata[DW +: DW] = '0;
    step();
    checks++;
    if ({rf_en, rf_we, rf_addr} !== {1'b1, 1'b0, 12'h004}) begin
      errors++;
      $display("FAIL read_issue: got en=%b we=%b addr=%h, required 1 0 004", rf_en, rf_we, rf_addr);
    end
    step();
    checks++;
    if (req_ack !== 2'b00 || busy !== 1'b1 || rf_en !== 1'b0) begin
      errors++;
      $display("FAIL read_wait: got ack=%b busy=%b en=%b, required 00 1 0", req_ack, busy, rf_en);
    end
    step();
    checks++;
    if (req_ack !== 2'b10 || req_rdata !== 32'h0000_0101) begin
      errors++;
      $display("FAIL read_ack: got ack=%b rdata=%h, required 10 00000101", req_ack, req_rdata);
    end
    req_valid = 2'b00;
    step();
    checks++;
    if (req_ack !== 2'b00 || req_rdata !== 32'h0000_0101) begin
      errors++;
      $display("FAIL read_hold: got ack=%b rdata=%h, required 00 00000101", req_ack, req_rdata);
    end
  endtask

  task automatic test_contention();
    logic [1:0]    got_ack  [4];
    logic [DW-1:0] got_data [4];
    int            got_cyc  [4];
    logic [1:0]    exp_ack;
    logic [DW-1:0] exp_data;
    int n_acks = 0;
    int c0;
    axi_aresetn = 1'b0;
    req_valid = 2'b11; req_we = 2'b00;
    req_addr = {12'h008, 12'h004};
    step(); step();
    axi_aresetn = 1'b1;
    c0 = cyc;
    for (int n = 0; n < 40 && n_acks < 4; n++) begin
      step();
      if (req_ack !== 2'b00) begin
        got_ack[n_acks] = req_ack; got_data[n_acks] = req_rdata; got_cyc[n_acks] = cyc;
        n_acks++;
      end
    end
    req_valid = 2'b00;
    checks++;
    if (n_acks != 4) begin
      errors++; $display("FAIL contention_timeout: got %0d acks, required 4", n_acks);
    end else begin
      checks++;
      if (got_cyc[0] != c0 + 3) begin
        errors++; $display("FAIL contention_first_ack: got cycle %0d, required %0d", got_cyc[0], c0 + 3);
      end
      for (int i = 0; i < 4; i++) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        exp_ack = 2'b01;
`else
        exp_ack = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
        exp_data = (exp_ack == 2'b01) ? 32'h0000_0101 : 32'hA5A5_A5A5;
        checks++;
        if (got_ack[i] !== exp_ack || got_data[i] !== exp_data) begin
          errors++;
          $display("FAIL contention_order[%0d]: got ack=%b rdata=%h, required %b %h",
                   i, got_ack[i], got_data[i], exp_ack, exp_data);
        end
        if (i > 0) begin
          checks++;
          if (got_cyc[i] - got_cyc[i-1] != 4) begin
            errors++;
            $display("FAIL contention_spacing[%0d]: got %0d cycles, required 4", i, got_cyc[i] - got_cyc[i-1]);
          end
        end
      end
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL contention_idle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid_read();
    req_valid = 2'b10; req_we = 2'b00; req_addr[AW +: AW] = 12'h008;
    step();
    checks++;
    if (rf_en !== 1'b1 || rf_addr !== 12'h008) begin
      errors++; $display("FAIL midrst_issue: got en=%b addr=%h, required 1 008", rf_en, rf_addr);
    end
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midrst_wait: got busy=%b, required 1", busy);
    end
    axi_aresetn = 1'b0;
    #1;
    checks++;
    if ({req_ack, req_rdata, rf_en, rf_we, rf_addr, rf_din, busy} !== '0) begin
      errors++;
      $display("FAIL midrst_clear: got ack=%b rdata=%h en=%b busy=%b, required all 0",
               req_ack, req_rdata, rf_en, busy);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (req_ack !== 2'b00 || rf_en !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_hold: got ack=%b en=%b busy=%b, required 00 0 0", req_ack, rf_en, busy);
      end
    end
    axi_aresetn = 1'b1;
    step();
    checks++;
    if (rf_en !== 1'b1 || rf_addr !== 12'h008) begin
      errors++; $display("FAIL midrst_reissue: got en=%b addr=%h, required 1 008", rf_en, rf_addr);
    end
    step();
    checks++;
    if (req_ack !== 2'b00) begin
      errors++; $display("FAIL midrst_early_ack: got ack=%b, required 00", req_ack);
    end
    step();
    checks++;
    if (req_ack !== 2'b10 || req_rdata !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL midrst_ack: got ack=%b rdata=%h, required 10 a5a5a5a5", req_ack, req_rdata);
    end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_rd_lat3();
    int c0;
    logic [DW-1:0] exp_data;
    req_valid3 = 2'b01; req_we3 = 2'b00; req_addr3[0 +: AW] = 12'h010;
    c0 = cyc;
    exp_data = 32'h3000_0000 | ((c0 + 4) & 32'h0000_FFFF);
    step();
    checks++;
    if (rf_en3 !== 1'b1 || rf_addr3 !== 12'h010) begin
      errors++; $display("FAIL lat3_issue: got en=%b addr=%h, required 1 010", rf_en3, rf_addr3);
    end
    for (int i = 2; i <= 4; i++) begin
      step();
      checks++;
      if (req_ack3 !== 2'b00 || busy3 !== 1'b1) begin
        errors++;
        $display("FAIL lat3_wait[C+%0d]: got ack=%b busy=%b, required 00 1", i, req_ack3, busy3);
      end
    end
    step();
    checks++;
    if (req_ack3 !== 2'b01 || req_rdata3 !== exp_data) begin
      errors++;
      $display("FAIL lat3_ack: got ack=%b rdata=%h, required 01 %h", req_ack3, req_rdata3, exp_data);
    end
    req_valid3 = 2'b00;
    step();
    checks++;
    if (req_ack3 !== 2'b00 || busy3 !== 1'b0) begin
      errors++; $display("FAIL lat3_done: got ack=%b busy=%b, required 00 0", req_ack3, busy3);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[1] = 32'h0000_0101;
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_reset_mid_read();
    test_rd_lat3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
